// File: rtl/sdp_bram_stim_gen.sv
// sdp_bram_stim_gen: four-phase write/read traffic generator
// (fill, readback, byte-enable, mixed collide) for an SDP BRAM.
module sdp_bram_stim_gen #(
    parameter int          DATA_WIDTH_A = 16,
    parameter int          ADDR_WIDTH_A = 4,
    parameter int          ADDR_WIDTH_B = 4,
    parameter int          BYTEEN_WIDTH = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          MIX_CYCLES   = 64
) (
    input  logic                    clk,
    input  logic                    bram_rst,
    input  logic                    start,
    input  logic                    hold,
    output logic                    wclke,
    output logic                    we,
    output logic                    waddren,
    output logic [ADDR_WIDTH_A-1:0] waddr,
    output logic [BYTEEN_WIDTH-1:0] byteen,
    output logic [DATA_WIDTH_A-1:0] wdata_a,
    output logic                    re,
    output logic                    raddren,
    output logic [ADDR_WIDTH_B-1:0] raddr,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              phase
);
    localparam int DEPTH_A = 2 ** ADDR_WIDTH_A;
    localparam int DEPTH_B = 2 ** ADDR_WIDTH_B;
    localparam int LEN_AB  = (DEPTH_A > DEPTH_B) ? DEPTH_A : DEPTH_B;
    localparam int MAXLEN  = (LEN_AB > MIX_CYCLES) ? LEN_AB : MIX_CYCLES;
    localparam int CW      = $clog2(MAXLEN) + 1;
    localparam int REP     = (DATA_WIDTH_A + 15) / 16;
    localparam int AWM     = (ADDR_WIDTH_A > ADDR_WIDTH_B) ? ADDR_WIDTH_A : ADDR_WIDTH_B;
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_READ = 3'd2,
        S_BYTE = 3'd3,
        S_MIX  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [15:0]             r_lfsr;
    logic                    r_wen;
    logic                    r_ren;
    logic                    r_aen;
    logic                    r_busy;
    logic                    r_done;
    logic [ADDR_WIDTH_A-1:0] r_waddr;
    logic [ADDR_WIDTH_B-1:0] r_raddr;
    logic [BYTEEN_WIDTH-1:0] r_byteen;
    logic [DATA_WIDTH_A-1:0] r_wdata;

    state_t                  w_nstate;
    state_t                  w_succ;
    logic [CW-1:0]           w_ncnt;
    logic [CW-1:0]           w_len_m1;
    logic                    w_adv;
    logic                    w_wr;
    logic                    w_rd;
    logic [15:0]             w_lfsr_nx;
    logic [16*REP-1:0]       w_rep;
    int                      w_bsel;
    logic [BYTEEN_WIDTH-1:0] w_onehot;
    logic [ADDR_WIDTH_B-1:0] w_rdec;
    logic [AWM-1:0]          w_raw;
    logic [ADDR_WIDTH_A-1:0] w_waddr;
    logic [ADDR_WIDTH_B-1:0] w_raddr;
    logic [BYTEEN_WIDTH-1:0] w_be;
    logic [DATA_WIDTH_A-1:0] w_wdata;

    // w_nstate/w_ncnt describe the beat presented after the next edge
    always_comb begin
        w_len_m1 = '0;
        w_succ   = S_IDLE;
        unique case (r_state)
            S_FILL: begin w_len_m1 = CW'(DEPTH_A - 1); w_succ = S_READ; end
            S_READ: begin w_len_m1 = CW'(DEPTH_B - 1); w_succ = S_BYTE; end
            S_BYTE: begin w_len_m1 = CW'(DEPTH_A - 1); w_succ = S_MIX;  end
            S_MIX:  begin w_len_m1 = CW'(MIX_CYCLES - 1); w_succ = S_DONE; end
            default: ;
        endcase

        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_adv    = 1'b0;
        unique case (r_state)
            S_IDLE: if (start) begin
                w_nstate = S_FILL;
                w_ncnt   = '0;
                w_adv    = 1'b1;
            end
            S_DONE: w_nstate = S_IDLE;
            default: if (!hold) begin
                if (r_cnt == w_len_m1) begin
                    w_nstate = w_succ;
                    w_ncnt   = '0;
                    w_adv    = (w_succ != S_DONE);
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                    w_adv  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_lfsr_nx = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400)
                              : {1'b0, r_lfsr[15:1]};
        w_rep     = {REP{r_lfsr}};
        w_bsel    = int'(w_ncnt) % BYTEEN_WIDTH;
        for (int i = 0; i < BYTEEN_WIDTH; i++) w_onehot[i] = (w_bsel == i);
        w_rdec    = w_ncnt[ADDR_WIDTH_B-1:0] - ADDR_WIDTH_B'(1);
        w_wr = w_adv && (w_nstate inside {S_FILL, S_BYTE, S_MIX});
        w_rd = w_adv && (w_nstate inside {S_READ, S_BYTE, S_MIX});
        w_waddr = r_waddr;
        w_raddr = r_raddr;
        w_be    = r_byteen;
        w_wdata = r_wdata;
        w_raw   = '0;
        unique case (w_nstate)
            S_FILL: begin
                w_waddr = w_ncnt[ADDR_WIDTH_A-1:0];
                w_be    = '1;
                w_wdata = w_rep[DATA_WIDTH_A-1:0];
            end
            S_READ: w_raddr = w_ncnt[ADDR_WIDTH_B-1:0];
            S_BYTE: begin
                w_waddr = w_ncnt[ADDR_WIDTH_A-1:0];
                w_be    = w_onehot;
                w_wdata = ~w_rep[DATA_WIDTH_A-1:0];
                w_raddr = w_rdec;
            end
            S_MIX: begin
                // even beats collide on the same address, odd ones hit the neighbour
                w_waddr = r_lfsr[ADDR_WIDTH_A-1:0];
                w_raw[ADDR_WIDTH_A-1:0] = w_waddr ^ ADDR_WIDTH_A'(w_ncnt[0]);
                w_raddr = w_raw[ADDR_WIDTH_B-1:0];
                w_be    = w_ncnt[0] ? r_lfsr[15-:BYTEEN_WIDTH] : '1;
                w_wdata = w_rep[DATA_WIDTH_A-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bram_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_lfsr   <= SEED;
            r_wen    <= 1'b0;
            r_ren    <= 1'b0;
            r_aen    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_waddr  <= '0;
            r_raddr  <= '0;
            r_byteen <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_aen   <= 1'b1;
            r_busy  <= (w_nstate != S_IDLE);
            r_done  <= (w_nstate == S_DONE);
            r_wen   <= w_wr;
            r_ren   <= w_rd;
            if (w_adv) begin
                r_waddr  <= w_waddr;
                r_raddr  <= w_raddr;
                r_byteen <= w_be;
                r_wdata  <= w_wdata;
            end
            if (w_wr) r_lfsr <= w_lfsr_nx;
        end
    end

    assign wclke   = r_wen;
    assign we      = r_wen;
    assign re      = r_ren;
    assign waddren = r_aen;
    assign raddren = r_aen;
    assign waddr   = r_waddr;
    assign raddr   = r_raddr;
    assign byteen  = r_byteen;
    assign wdata_a = r_wdata;
    assign busy    = r_busy;
    assign done    = r_done;
    assign phase   = r_state;
endmodule

// File: tb/tb_sdp_bram_stim_gen.sv
// Bench for sdp_bram_stim_gen: random hold/start stimulus scored
// against a phase-level transaction list built from the sequence rules.
`timescale 1ns/1ps
module tb_sdp_bram_stim_gen;
    localparam int DW = 16, AWA = 4, AWB = 4, BW = 2, MIXN = 64;
    localparam int DA = 16, DB = 16;
    localparam int SEQ_LEN = 2 * DA + DB + MIXN + 1;

    logic clk = 1'b0;
    logic bram_rst, start, hold;
    logic wclke, we, waddren, re, raddren, busy, done;
    logic [AWA-1:0] waddr;
    logic [AWB-1:0] raddr;
    logic [BW-1:0]  byteen;
    logic [DW-1:0]  wdata_a;
    logic [2:0]     phase;
    logic wclke0, we0, waddren0, re0, raddren0, busy0, done0;
    logic [AWA-1:0] waddr0;
    logic [AWB-1:0] raddr0;
    logic [BW-1:0]  byteen0;
    logic [DW-1:0]  wdata0;
    logic [2:0]     phase0;

    sdp_bram_stim_gen u_dut (
        .clk(clk), .bram_rst(bram_rst), .start(start), .hold(hold),
        .wclke(wclke), .we(we), .waddren(waddren), .waddr(waddr),
        .byteen(byteen), .wdata_a(wdata_a), .re(re), .raddren(raddren),
        .raddr(raddr), .busy(busy), .done(done), .phase(phase)
    );

    sdp_bram_stim_gen #(.LFSR_SEED(16'h0000)) u_dut0 (
        .clk(clk), .bram_rst(bram_rst), .start(start), .hold(hold),
        .wclke(wclke0), .we(we0), .waddren(waddren0), .waddr(waddr0),
        .byteen(byteen0), .wdata_a(wdata0), .re(re0), .raddren(raddren0),
        .raddr(raddr0), .busy(busy0), .done(done0), .phase(phase0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           ph;
        bit           w;
        bit           r;
        logic [AWA-1:0] wa;
        logic [AWB-1:0] ra;
        logic [BW-1:0]  be;
        logic [DW-1:0]  wd;
    } beat_t;

    beat_t       q[$];
    logic [15:0] mlfsr;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_seed0 = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_model();
        beat_t b;
        logic [BW-1:0] bev;
        int rv;
        q.delete();
        for (int a = 0; a < DA; a++) begin
            b = '{ph: 1, w: 1, r: 0, wa: a[AWA-1:0], ra: '0, be: '1, wd: mlfsr};
            q.push_back(b);
            mlfsr = lfsr_next(mlfsr);
        end
        for (int a = 0; a < DB; a++) begin
            b = '{ph: 2, w: 0, r: 1, wa: '0, ra: a[AWB-1:0], be: '0, wd: '0};
            q.push_back(b);
        end
        for (int a = 0; a < DA; a++) begin
            bev = '0;
            bev[a % BW] = 1'b1;
            rv = (a == 0) ? DB - 1 : a - 1;
            b = '{ph: 3, w: 1, r: 1, wa: a[AWA-1:0], ra: rv[AWB-1:0], be: bev, wd: ~mlfsr};
            q.push_back(b);
            mlfsr = lfsr_next(mlfsr);
        end
        for (int k = 0; k < MIXN; k++) begin
            b.ph = 4; b.w = 1; b.r = 1;
            b.wa = mlfsr[AWA-1:0];
            b.ra = (k % 2 == 0) ? mlfsr[AWB-1:0] : (mlfsr[AWB-1:0] ^ 4'd1);
            b.be = (k % 2 == 0) ? 2'b11 : mlfsr[15:14];
            b.wd = mlfsr;
            q.push_back(b);
            mlfsr = lfsr_next(mlfsr);
        end
    endtask

    task automatic run_seq(input int hold_pct, input bit hold7, input bit keep_start);
        int cyc, eff, hold_left, prev_ph;
        bit prev_hold, fin, did7;
        logic [AWA-1:0] last_wa;
        logic [DW-1:0] last_wd;
        beat_t e;
        build_model();
        start = 1; hold = 0;
        prev_ph = 0; prev_hold = 0; eff = 0; hold_left = 0; fin = 0; did7 = 0;
        step();
        cyc = 1;
        if (!keep_start) start = 0;
        if (chk_seed0) begin
            n_cmp++;
            if (wdata0 !== 16'h0001) begin
                n_bad++;
                $display("FAIL seed0_wdata: got %h want 0001", wdata0);
            end
            chk_seed0 = 0;
        end
        while (!fin && cyc < 4 * SEQ_LEN + 50) begin
            if (phase inside {[3'd1:3'd4]}) begin
                n_cmp++;
                if ({busy, done, waddren, raddren} !== 4'b1011) begin
                    n_bad++;
                    $display("FAIL status: got bdwr=%b want 1011 cyc=%0d",
                             {busy, done, waddren, raddren}, cyc);
                end
                if (prev_hold && prev_ph inside {[1:4]}) begin
                    n_cmp++;
                    if ({phase, wclke, we, re, waddr, wdata_a} !==
                        {3'(prev_ph), 3'b000, last_wa, last_wd}) begin
                        n_bad++;
                        $display("FAIL stall: got ph=%0d en=%b wa=%h wd=%h want ph=%0d en=000 wa=%h wd=%h",
                                 phase, {wclke, we, re}, waddr, wdata_a, prev_ph, last_wa, last_wd);
                    end
                end else if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got ph=%0d want DONE", phase);
                end else begin
                    e = q.pop_front();
                    n_cmp++;
                    if ({phase, wclke, we, re} !== {3'(e.ph), e.w, e.w, e.r}) begin
                        n_bad++;
                        $display("FAIL beat_ctl: got ph=%0d en=%b want ph=%0d en=%b",
                                 phase, {wclke, we, re}, e.ph, {e.w, e.w, e.r});
                    end
                    if (e.w) begin
                        n_cmp++;
                        if ({waddr, byteen, wdata_a} !== {e.wa, e.be, e.wd}) begin
                            n_bad++;
                            $display("FAIL write: got wa=%h be=%b wd=%h want wa=%h be=%b wd=%h",
                                     waddr, byteen, wdata_a, e.wa, e.be, e.wd);
                        end
                    end
                    if (e.r) begin
                        n_cmp++;
                        if (raddr !== e.ra) begin
                            n_bad++;
                            $display("FAIL raddr: got %h want %h (ph=%0d)", raddr, e.ra, e.ph);
                        end
                    end
                end
            end else if (phase == 3'd5) begin
                n_cmp++;
                if ({busy, done, wclke, we, re} !== 5'b11000 || q.size() != 0) begin
                    n_bad++;
                    $display("FAIL done_state: got bd_en=%b left=%0d want 11000 left=0",
                             {busy, done, wclke, we, re}, q.size());
                end
                n_cmp++;
                if (cyc != SEQ_LEN + eff) begin
                    n_bad++;
                    $display("FAIL done_time: got %0d want %0d", cyc, SEQ_LEN + eff);
                end
                fin = 1;
            end else begin
                n_cmp++;
                n_bad++;
                $display("FAIL phase: got %0d want 1..5", phase);
                fin = 1;
            end
            if (!fin) begin
                last_wa = waddr;
                last_wd = wdata_a;
                prev_ph = int'(phase);
                if (hold_left > 0) begin
                    hold = 1;
                    hold_left--;
                end else if (hold7 && !did7 && phase == 3'd1 && we && waddr == 4'd7) begin
                    hold = 1;
                    hold_left = 4;
                    did7 = 1;
                end else begin
                    hold = ($urandom_range(99) < hold_pct);
                end
                if (hold) eff++;
                prev_hold = hold;
                step();
                cyc++;
            end
        end
        hold = 0;
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no DONE after %0d cycles want %0d", cyc, SEQ_LEN + eff);
        end
        step();
        n_cmp++;
        if ({phase, busy, done, wclke, we, re} !== 8'h00) begin
            n_bad++;
            $display("FAIL post_idle: got ph=%0d b=%b d=%b en=%b want all 0",
                     phase, busy, done, {wclke, we, re});
        end
    endtask

    task automatic check_zero(input string nm);
        n_cmp++;
        if ({wclke, we, waddren, waddr, byteen, wdata_a, re, raddren,
             raddr, busy, done, phase} !== '0) begin
            n_bad++;
            $display("FAIL %s: got ph=%0d en=%b aen=%b%b wa=%h ra=%h be=%b wd=%h b=%b d=%b want all 0",
                     nm, phase, {wclke, we, re}, waddren, raddren, waddr, raddr,
                     byteen, wdata_a, busy, done);
        end
    endtask

    task automatic test_reset();
        bram_rst = 1; start = 0; hold = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_zero("reset");
        end
        bram_rst = 0;
        mlfsr = 16'hACE1;
    endtask

    task automatic test_full_sequence();
        for (int i = 0; i < 6; i++) begin
            start = 0;
            hold = 1;
            step();
            n_cmp++;
            if ({phase, busy, wclke, we, re} !== 7'b0) begin
                n_bad++;
                $display("FAIL idle: got ph=%0d busy=%b en=%b want 0", phase, busy, {wclke, we, re});
            end
        end
        hold = 0;
        chk_seed0 = 1;
        run_seq(0, 0, 0);
    endtask

    task automatic test_hold_fill7();
        run_seq(0, 1, 0);
    endtask

    task automatic test_random_hold();
        run_seq(25, 0, 0);
        run_seq(60, 0, 0);
    endtask

    task automatic test_start_held();
        run_seq(10, 0, 1);
        run_seq(0, 0, 0);
    endtask

    task automatic test_reset_mid_mix();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 300 && phase != 3'd4; i++) step();
        repeat (7) step();
        n_cmp++;
        if (phase !== 3'd4) begin
            n_bad++;
            $display("FAIL reach_mix: got %0d want 4", phase);
        end
        bram_rst = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_zero("reset_mid_mix");
        end
        bram_rst = 0;
        mlfsr = 16'hACE1;
        step();
        run_seq(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_hold_fill7();
        test_random_hold();
        test_start_held();
        test_reset_mid_mix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
